// File: rtl/baudgen_frac_if.sv
`default_nettype none
// ============================================================================
//  Module      : baudgen_frac_if
//  Description : Control/status bundle for the fractional baud tick generator.
//                The master side (host/controller) drives the run enable and
//                the divisor load strobe. The slave side (the generator)
//                returns the bit-timing ticks and the configuration status.
//  Signals     : clk_ena     - run enable, low holds the generator idle
//                div_int     - new integer divisor (clocks per bit)
//                div_frac    - new fractional divisor (div_frac / 2^FRAC_W)
//                div_load    - one-cycle strobe capturing div_int/div_frac
//                tick_os     - oversample tick
//                tick_mid    - mid-bit tick
//                tick_bit    - end-of-bit tick
//                cfg_pending - a loaded divisor waits for the next boundary
//                cfg_err     - the last load was clamped up to OSR
//  Revision    : 1.0 - initial release
// ============================================================================
interface baudgen_frac_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              clk_ena;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              tick_os;
    logic              tick_mid;
    logic              tick_bit;
    logic              cfg_pending;
    logic              cfg_err;

    modport master (
        output clk_ena, div_int, div_frac, div_load,
        input  tick_os, tick_mid, tick_bit, cfg_pending, cfg_err
    );

    modport slave (
        input  clk_ena, div_int, div_frac, div_load,
        output tick_os, tick_mid, tick_bit, cfg_pending, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/baudgen_frac.sv
`default_nettype none
// ============================================================================
//  Module      : baudgen_frac
//  Description : Runtime-programmable fractional-divisor baud tick generator.
//                A bit lasts div_a (+1 when the fractional accumulator
//                overflows) clocks. Within each bit it emits OSR oversample
//                ticks spaced div_a/OSR apart, one mid-bit tick and one
//                end-of-bit tick. New divisors are staged in a pending
//                register and only take effect on a bit boundary (or at once
//                while idle), so a running bit period is never glitched.
//  Ports       : clk  - system clock
//                rst  - asynchronous reset, active-high
//                bus  - baudgen_frac_if slave modport (enable, divisor load,
//                       ticks and configuration status)
//  Revision    : 1.0 - initial release
// ============================================================================
module baudgen_frac #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OSR          = 16,
    parameter int DEFAULT_DIV  = 434,
    parameter int DEFAULT_FRAC = 0
) (
    input  logic           clk,
    input  logic           rst,
    baudgen_frac_if.slave  bus
);

    localparam int                OSR_LOG2 = $clog2(OSR);
    // os_num must be able to hold the value OSR itself (saturated state).
    localparam int                NUM_W    = OSR_LOG2 + 1;
    localparam logic [DIV_W-1:0]  C_DEF_DIV  = DIV_W'(DEFAULT_DIV);
    localparam logic [FRAC_W-1:0] C_DEF_FRAC = FRAC_W'(DEFAULT_FRAC);
    localparam logic [DIV_W-1:0]  C_OSR_DIV  = DIV_W'(OSR);
    localparam logic [NUM_W-1:0]  C_OSR_NUM  = NUM_W'(OSR);
    localparam logic [DIV_W-1:0]  C_ONE_DIV  = DIV_W'(1);
    localparam logic [DIV_W:0]    C_ONE_LEN  = (DIV_W+1)'(1);
    localparam logic [NUM_W-1:0]  C_ONE_NUM  = NUM_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]  div_a;       // active integer divisor
    logic [FRAC_W-1:0] frac_a;      // active fractional divisor
    logic [DIV_W-1:0]  pend_div;    // staged integer divisor (already clamped)
    logic [FRAC_W-1:0] pend_frac;   // staged fractional divisor
    logic              pending;     // staged value not yet applied
    logic              err_q;       // last load was clamped

    logic [DIV_W-1:0]  cnt;         // position within the current bit
    logic [DIV_W-1:0]  os_cnt;      // position within the current OS slot
    logic [NUM_W-1:0]  os_num;      // oversample ticks issued this bit
    logic [FRAC_W-1:0] acc;         // fractional phase accumulator
    logic              carry;       // stretches the current bit by one clock

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]  os_div;
    logic [DIV_W:0]    bit_len;
    logic [DIV_W:0]    bit_last;
    logic              at_end;
    logic              at_mid;
    logic              os_slot0;
    logic              os_wrap;
    logic              os_live;
    logic              boundary;
    logic              os_fire;
    logic              apply;
    logic              load_low;
    logic [DIV_W-1:0]  load_div;
    logic              out_en;

    assign os_div   = div_a >> OSR_LOG2;
    assign bit_len  = {1'b0, div_a} + {{DIV_W{1'b0}}, carry};
    assign bit_last = bit_len - C_ONE_LEN;
    assign at_end   = ({1'b0, cnt} == bit_last);
    assign at_mid   = (cnt == (div_a >> 1));
    assign os_slot0 = (os_cnt == '0);
    assign os_wrap  = (os_cnt == (os_div - C_ONE_DIV));
    // Once OSR ticks have been issued, the remainder clocks of the bit stay
    // silent even though os_cnt keeps wrapping.
    assign os_live  = (os_num < C_OSR_NUM);

    assign boundary = bus.clk_ena && at_end;
    assign os_fire  = bus.clk_ena && os_slot0 && os_live;

    // A staged divisor is taken over on a bit boundary while running, or on
    // any edge while idle (there is no bit in flight to protect then).
    assign apply    = pending && (!bus.clk_ena || at_end);

    // Divisors below OSR would give a zero-length oversample slot.
    assign load_low = (bus.div_int < C_OSR_DIV);
    assign load_div = load_low ? C_OSR_DIV : bus.div_int;

    // Ticks also drop while reset is held so every output reads 0 in reset,
    // including the cycle where cnt=0 would otherwise flag tick_os.
    assign out_en   = bus.clk_ena && !rst;

    assign bus.tick_os     = out_en && os_slot0 && os_live;
    assign bus.tick_mid    = out_en && at_mid;
    assign bus.tick_bit    = out_en && at_end;
    assign bus.cfg_pending = pending;
    assign bus.cfg_err     = err_q;

    // ------------------------------------------------------------------
    // Configuration: staging and application of divisors
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_a     <= C_DEF_DIV;
            frac_a    <= C_DEF_FRAC;
            pend_div  <= C_DEF_DIV;
            pend_frac <= C_DEF_FRAC;
            pending   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // The value applied here is the one staged before this edge; a
            // load arriving in the same cycle is kept for the next boundary.
            if (apply) begin
                div_a  <= pend_div;
                frac_a <= pend_frac;
            end
            if (bus.div_load) begin
                pend_div  <= load_div;
                pend_frac <= bus.div_frac;
                pending   <= 1'b1;
                err_q     <= load_low;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bit timing counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            os_cnt <= '0;
            os_num <= '0;
            acc    <= '0;
            carry  <= 1'b0;
        end else if (!bus.clk_ena) begin
            // Idle abandons any partial bit; re-enable starts a fresh bit.
            cnt    <= '0;
            os_cnt <= '0;
            os_num <= '0;
            acc    <= '0;
            carry  <= 1'b0;
        end else if (boundary) begin
            cnt    <= '0;
            os_cnt <= '0;
            os_num <= '0;
            if (apply) begin
                // A new divisor starts with a clean fractional phase.
                acc   <= '0;
                carry <= 1'b0;
            end else begin
                {carry, acc} <= {1'b0, acc} + {1'b0, frac_a};
            end
        end else begin
            cnt    <= cnt + C_ONE_DIV;
            os_cnt <= os_wrap ? '0 : (os_cnt + C_ONE_DIV);
            if (os_fire) begin
                os_num <= os_num + C_ONE_NUM;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/baudgen_frac.md
Name: baudgen_frac

Overview:
- Runtime-programmable, fractional-divisor baud tick generator for the UART comm path.
- Produces per-bit oversample ticks, a mid-bit sample tick and an end-of-bit tick from the system clock.
- Divisor can be changed at run time without glitching a bit period.
- Drop-in source of bit timing for the RX deserialiser and TX serialiser of the sparse-matrix host link.

Parameters:
- DIV_W, 16: width of integer divisor (clocks per bit).
- FRAC_W, 4: width of fractional divisor; fraction = div_frac / 2^FRAC_W.
- OSR, 16: oversample ticks per bit; power of two, ≥ 2.
- DEFAULT_DIV, 434: integer divisor after reset (115200 baud at 50 MHz).
- DEFAULT_FRAC, 0: fractional divisor after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- clk_ena  in  1  run enable; low holds the generator idle
- div_int  in  DIV_W  new integer divisor
- div_frac  in  FRAC_W  new fractional divisor
- div_load  in  1  one-cycle strobe capturing div_int/div_frac
- tick_os  out  1  oversample tick, one cycle wide
- tick_mid  out  1  mid-bit tick, one cycle wide
- tick_bit  out  1  end-of-bit tick, one cycle wide
- cfg_pending  out  1  a loaded divisor is waiting to be applied
- cfg_err  out  1  last load was below OSR and was clamped

Behaviour:
- Reset (async, rst=1):
  - active div = DEFAULT_DIV, frac = DEFAULT_FRAC.
  - cnt, os_cnt, os_num, acc and carry = 0.
  - All outputs 0.
- Active registers: div_a, frac_a; OS_DIV = div_a >> log2(OSR).
- Bit length: len = div_a + carry.
- cnt counts 0..len-1 while clk_ena=1. While clk_ena=0: cnt, os_cnt, os_num, acc and carry are held at 0.
- Start-up timing: if clk_ena is first high in cycle k, cnt=0 in cycle k, tick_mid is in cycle k + (div_a>>1), and tick_bit is in cycle k + len - 1.
- All ticks are combinational from registers, gated by clk_ena. No extra latency.
- tick_mid = clk_ena && cnt == div_a>>1. Exactly one per bit.
- tick_bit = clk_ena && cnt == len-1. In that cycle the bit boundary occurs:
  - cnt←0, os_cnt←0, os_num←0.
  - {carry, acc} ← acc + frac_a. The carry out of FRAC_W bits sets the next bit's length.
- os_cnt counts 0..OS_DIV-1 and restarts at the bit boundary.
- tick_os = clk_ena && os_cnt==0 && os_num<OSR; os_num increments on each tick_os. Exactly OSR pulses per bit, at cnt = 0, OS_DIV, 2·OS_DIV, … The remainder cycles at the end of the bit produce none.
- Divisor loading:
  - div_load captures the inputs into a pending register and sets cfg_pending.
  - Values with div_int < OSR are clamped to OSR, and cfg_err is set.
  - A legal load clears cfg_err.
  - A load while pending overwrites the pending value; last one wins.
- Divisor apply:
  - With clk_ena=1, pending is applied on the tick_bit cycle edge. The next bit uses the new divisor, and acc/carry are cleared.
  - With clk_ena=0, pending is applied on the next edge.
  - cfg_pending clears when the value is applied.
  - div_load coinciding with tick_bit: the new value is captured and pending, but is applied at the following boundary, not this one.
- Fraction example: with frac=8 and FRAC_W=4, bit lengths are D, D, D+1, D, D+1, … (average D+0.5 after the first bit).
- clk_ena deasserted mid-bit: the partial bit is abandoned and no ticks are emitted. Re-enable restarts at cnt=0. Pending config is applied while idle.
- rst mid-operation: immediate return to reset values. A pending load is discarded.

Test Plan:
- Reset, clk_ena=1 from cycle 0, defaults (434/0, OSR 16) -> tick_mid at cycles 217, 651, …; tick_bit at 433, 867, …; tick_os at cnt 0, 27, …, 405 (16 per bit).
- div_load 100/frac 8 while running -> cfg_pending until the next tick_bit; then bit lengths are 100, 100, 101, 100, 101; tick_mid at cnt 50 in each bit; cfg_pending drops.
- div_load div_int=5 (OSR 16) -> applied value is 16, cfg_err=1, OS_DIV=1, 16 tick_os per bit; a later load of 434 clears cfg_err.
- Drop clk_ena at cnt=300, hold low 10 cycles, then reassert -> no ticks while low; first tick_mid 217 cycles after reassertion.
- div_load in the same cycle as tick_bit -> current boundary keeps the old divisor; new value is applied one bit later.
- Assert rst asynchronously mid-bit with a load pending -> all outputs 0 immediately, cfg_pending=0, divisor back to 434.
